// File: rtl/cic_pkg.sv
// Shared types and helpers for the multi-channel CIC decimator.
package cic_pkg;

  typedef logic signed [63:0] wide_t;
  typedef logic [5:0]         shift_t;

  // Minimum accumulator width that still lets the combs undo integrator wrap.
  function automatic int cic_min_internal_bits(input int in_bits, input int order,
                                               input int rate, input int delay);
    return in_bits + order * $clog2(rate * delay);
  endfunction

  // Round half up, arithmetic shift, then clamp to a signed out_bits range.
  function automatic wide_t cic_round_sat(input wide_t x, input shift_t shift, input int out_bits);
    wide_t rnd, y, hi, lo;
    rnd = (shift == 6'd0) ? '0 : (wide_t'(1) <<< (shift - 6'd1));
    y   = (x + rnd) >>> shift;
    hi  = (wide_t'(1) <<< (out_bits - 1)) - wide_t'(1);
    lo  = -(wide_t'(1) <<< (out_bits - 1));
    if (y > hi)      y = hi;
    else if (y < lo) y = lo;
    return y;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb stage with per-channel delay lines of depth DelayLength.
module cic_comb_stage #(
  parameter int Width       = 30,
  parameter int NumChannels = 4,
  parameter int ChannelBits = 2,
  parameter int DelayLength = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall,
  input  logic                   in_valid,
  input  logic [ChannelBits-1:0] in_channel,
  input  logic [Width-1:0]       in_data,
  output logic                   out_valid,
  output logic [ChannelBits-1:0] out_channel,
  output logic [Width-1:0]       out_data
);

  logic [NumChannels-1:0][DelayLength-1:0][Width-1:0] dly;
  logic [Width-1:0] x_dly;

  always_comb begin
    x_dly = '0;
    for (int i = 0; i < NumChannels; i++)
      if (int'(in_channel) == i) x_dly = dly[i][DelayLength-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_data    <= '0;
      dly         <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_data    <= '0;
      dly         <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_channel <= in_channel;
        out_data    <= in_data - x_dly;
        // Only the channel being processed advances its delay line.
        for (int i = 0; i < NumChannels; i++) begin
          if (int'(in_channel) == i) begin
            dly[i][0] <= in_data;
            for (int k = 1; k < DelayLength; k++) dly[i][k] <= dly[i][k-1];
          end
        end
      end
    end
  end

endmodule

// File: rtl/cic_decimator_mc.sv
// Multi-channel TDM CIC decimator: per-channel integrators, runtime rate,
// pipelined combs, round/shift/saturate output on a valid/ready stream.
module cic_decimator_mc
  import cic_pkg::*;
#(
  parameter int InputLengthBits    = 12,
  parameter int NumChannels        = 4,
  parameter int FilterOrder        = 3,
  parameter int DelayLength        = 1,
  parameter int MaxDecimation      = 64,
  parameter int InternalLengthBits = 30,
  parameter int OutputLengthBits   = 16,
  parameter int ChannelBits        = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [$clog2(MaxDecimation+1)-1:0]   rate,
  input  logic [5:0]                           shift,
  input  logic                                 cfg_load,
  input  logic [InputLengthBits-1:0]           in,
  input  logic [ChannelBits-1:0]               in_channel,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [OutputLengthBits-1:0]          out,
  output logic [ChannelBits-1:0]               out_channel,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int IW = InternalLengthBits;
  localparam int N  = FilterOrder;
  localparam int RW = $clog2(MaxDecimation+1);

  if (IW < cic_min_internal_bits(InputLengthBits, FilterOrder, MaxDecimation, DelayLength)) begin : g_width_check
    $error("InternalLengthBits too small for worst-case CIC growth");
  end

  logic stall, accept, ch_ok;
  logic [RW-1:0] rate_q;
  shift_t        shift_q;

  logic [NumChannels-1:0][N-1:0][IW-1:0] integ;
  logic [NumChannels-1:0][RW-1:0]        phase;
  logic [N-1:0][IW-1:0] cur, nxt;
  logic [RW-1:0]        cur_ph;
  logic [IW-1:0]        in_ext;

  logic                   int_vld;
  logic [ChannelBits-1:0] int_ch;
  logic [IW-1:0]          int_dat;

  logic [N:0]                  vld_pipe;
  logic [N:0][ChannelBits-1:0] ch_pipe;
  logic [N:0][IW-1:0]          dat_pipe;
  logic [OutputLengthBits-1:0] y_sat;

  // The whole pipeline freezes while a result sits unaccepted at the output.
  assign stall    = out_valid && !out_ready;
  assign in_ready = rst && !cfg_load && !stall;
  assign accept   = in_valid && in_ready;
  assign ch_ok    = int'(in_channel) < NumChannels;
  assign in_ext   = {{(IW-InputLengthBits){in[InputLengthBits-1]}}, in};

  always_comb begin
    cur    = '0;
    cur_ph = '0;
    nxt    = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (int'(in_channel) == i) begin
        cur    = integ[i];
        cur_ph = phase[i];
      end
    end
    // Cascade uses pre-update values so all N stages settle in one cycle.
    nxt[0] = cur[0] + in_ext;
    for (int k = 1; k < N; k++) nxt[k] = cur[k] + cur[k-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rate_q  <= RW'(2);
      shift_q <= '0;
    end else if (cfg_load) begin
      if (rate < RW'(2))                  rate_q <= RW'(2);
      else if (rate > RW'(MaxDecimation)) rate_q <= RW'(MaxDecimation);
      else                                rate_q <= rate;
      shift_q <= shift;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      integ   <= '0;
      phase   <= '0;
      int_vld <= 1'b0;
      int_ch  <= '0;
      int_dat <= '0;
    end else if (cfg_load) begin
      integ   <= '0;
      phase   <= '0;
      int_vld <= 1'b0;
      int_ch  <= '0;
      int_dat <= '0;
    end else if (!stall) begin
      int_vld <= 1'b0;
      if (accept && ch_ok) begin
        for (int i = 0; i < NumChannels; i++) begin
          if (int'(in_channel) == i) begin
            integ[i] <= nxt;
            if (cur_ph == rate_q - RW'(1)) begin
              phase[i] <= '0;
              int_vld  <= 1'b1;
              int_ch   <= in_channel;
              int_dat  <= nxt[N-1];
            end else begin
              phase[i] <= cur_ph + RW'(1);
            end
          end
        end
      end
    end
  end

  assign vld_pipe[0] = int_vld;
  assign ch_pipe[0]  = int_ch;
  assign dat_pipe[0] = int_dat;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(
      .Width(IW), .NumChannels(NumChannels), .ChannelBits(ChannelBits), .DelayLength(DelayLength)
    ) u_comb (
      .clk        (clk),
      .rst        (rst),
      .flush      (cfg_load),
      .stall      (stall),
      .in_valid   (vld_pipe[k]),
      .in_channel (ch_pipe[k]),
      .in_data    (dat_pipe[k]),
      .out_valid  (vld_pipe[k+1]),
      .out_channel(ch_pipe[k+1]),
      .out_data   (dat_pipe[k+1])
    );
  end

  assign y_sat = OutputLengthBits'(cic_round_sat({{(64-IW){dat_pipe[N][IW-1]}}, dat_pipe[N]},
                                                 shift_q, OutputLengthBits));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out         <= '0;
      out_channel <= '0;
      out_valid   <= 1'b0;
    end else if (cfg_load) begin
      out         <= '0;
      out_channel <= '0;
      out_valid   <= 1'b0;
    end else if (!stall) begin
      out_valid <= vld_pipe[N];
      if (vld_pipe[N]) begin
        out         <= y_sat;
        out_channel <= ch_pipe[N];
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Scoreboard bench for cic_decimator_mc: a behavioural model pushes expected
// results on accept, an output monitor pops and compares on each transfer.
module tb_cic_decimator_mc;

  localparam int NCH = 4;
  localparam int N   = 3;
  localparam int IW  = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  rate = 7'd2;
  logic [5:0]  shift = 6'd0;
  logic        cfg_load = 1'b0;
  logic [11:0] in = '0;
  logic [1:0]  in_channel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out;
  logic [1:0]  out_channel;
  logic        out_valid;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;

  cic_decimator_mc dut (
    .clk(clk), .rst(rst), .rate(rate), .shift(shift), .cfg_load(cfg_load),
    .in(in), .in_channel(in_channel), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct { int ch; int val; } res_t;
  res_t exp_q[$];
  res_t got_q[$];
  int checks = 0;
  int failures = 0;

  logic [IW-1:0] m_int [NCH][N];
  logic [IW-1:0] m_dly [N][NCH];
  int m_ph [NCH];
  int m_rate, m_shift, m_accepts;

  task automatic model_reset(input int r, input int s);
    for (int c = 0; c < NCH; c++) begin
      m_ph[c] = 0;
      for (int k = 0; k < N; k++) begin
        m_int[c][k] = '0;
        m_dly[k][c] = '0;
      end
    end
    m_rate = r; m_shift = s; m_accepts = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int ch, input int x);
    logic [IW-1:0] xe, n0, n1, n2, v, d;
    longint s;
    res_t r;
    m_accepts++;
    if (ch >= NCH) return;
    xe = IW'(x);
    n0 = m_int[ch][0] + xe;
    n1 = m_int[ch][1] + m_int[ch][0];
    n2 = m_int[ch][2] + m_int[ch][1];
    m_int[ch][0] = n0; m_int[ch][1] = n1; m_int[ch][2] = n2;
    if (m_ph[ch] == m_rate - 1) begin
      m_ph[ch] = 0;
      v = n2;
      for (int k = 0; k < N; k++) begin
        d = v - m_dly[k][ch];
        m_dly[k][ch] = v;
        v = d;
      end
      s = longint'($signed(v));
      if (m_shift > 0) s = (s + (longint'(1) << (m_shift - 1))) >>> m_shift;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      r.ch = ch; r.val = int'(s);
      exp_q.push_back(r);
    end else begin
      m_ph[ch]++;
    end
  endtask

  // Output monitor: a transfer happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    res_t e, g;
    logic signed [15:0] ev;
    if (rst && out_valid && out_ready) begin
      g.ch = int'(out_channel); g.val = int'($signed(out));
      got_q.push_back(g);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out: got ch=%0d val=%0d, required no output", g.ch, g.val);
      end else begin
        e = exp_q.pop_front();
        ev = 16'(e.val);
        if (out !== ev || out_channel !== 2'(e.ch)) begin
          failures++;
          $display("FAIL scoreboard: got ch=%0d val=%0d, required ch=%0d val=%0d",
                   g.ch, g.val, e.ch, e.val);
        end
      end
    end
  end

  task automatic send(input int ch, input int x);
    bit done = 0;
    int n = 0;
    in = 12'(x); in_channel = 2'(ch); in_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(ch, x);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: sample ch=%0d not accepted within 200 cycles", ch);
    end
  endtask

  task automatic try_send(input int ch, input int x);
    in = 12'(x); in_channel = 2'(ch); in_valid = 1'b1;
    @(negedge clk);
    if (in_ready) model_accept(ch, x);
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int r, input int s);
    int rc;
    cfg_load = 1'b1; rate = 7'(r); shift = 6'(s);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL cfg_in_ready: got %b, required 0", in_ready);
    end
    @(posedge clk); #1;
    cfg_load = 1'b0;
    rc = (r < 2) ? 2 : (r > 64) ? 64 : r;
    model_reset(rc, s);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    in_valid = 1'b1; in = 12'hAAA; in_channel = 2'd1;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if (out !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: out=%h out_valid=%b in_ready=%b, required 0/0/0",
                 out, out_valid, in_ready);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    model_reset(2, 0);
  endtask

  task automatic test_dc_gain();
    int n = 0;
    cfg(5, 0);
    got_q.delete();
    repeat (5) send(0, 1);
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL dc_latency: out_valid after %0d further edges, required 4", n);
    end
    repeat (30) send(0, 1);
    drain();
    checks++;
    if (got_q.size() != 7) begin
      failures++;
      $display("FAIL dc_count: got %0d outputs, required 7", got_q.size());
    end
    for (int j = 4; j < got_q.size(); j++) begin
      checks++;
      if (got_q[j].val != 125 || got_q[j].ch != 0) begin
        failures++;
        $display("FAIL dc_gain: got ch=%0d val=%0d, required ch=0 val=125", got_q[j].ch, got_q[j].val);
      end
    end
  endtask

  task automatic test_channel_isolation();
    cfg(5, 0);
    got_q.delete();
    for (int i = 0; i < 40; i++) begin
      send(0, 1);
      send(1, -2);
    end
    drain();
    checks++;
    if (got_q.size() != 16) begin
      failures++;
      $display("FAIL iso_count: got %0d outputs, required 16", got_q.size());
    end
    for (int j = 8; j < got_q.size(); j++) begin
      checks++;
      if (got_q[j].ch != (j % 2) || got_q[j].val != ((j % 2) ? -250 : 125)) begin
        failures++;
        $display("FAIL iso_value: idx %0d got ch=%0d val=%0d, required ch=%0d val=%0d",
                 j, got_q[j].ch, got_q[j].val, j % 2, (j % 2) ? -250 : 125);
      end
    end
  endtask

  task automatic test_rate_round();
    int req [4] = '{48, 94, 8, 1};
    int rt  [4] = '{4, 5, 0, 100};
    int sh  [4] = '{2, 2, 0, 18};
    int ns  [4] = '{32, 40, 40, 320};
    int x   [4] = '{3, 3, 1, 1};
    for (int t = 0; t < 4; t++) begin
      cfg(rt[t], sh[t]);
      got_q.delete();
      repeat (ns[t]) send(0, x[t]);
      drain();
      checks++;
      if (got_q.size() == 0 || got_q[got_q.size()-1].val != req[t]) begin
        failures++;
        $display("FAIL rate_round[%0d]: got %0d, required %0d", t,
                 (got_q.size() == 0) ? 0 : got_q[got_q.size()-1].val, req[t]);
      end
    end
  endtask

  task automatic test_saturation();
    int x   [2] = '{2047, -2048};
    int req [2] = '{32767, -32768};
    for (int t = 0; t < 2; t++) begin
      cfg(5, 0);
      got_q.delete();
      repeat (30) send(2, x[t]);
      drain();
      checks++;
      if (got_q.size() == 0 || got_q[got_q.size()-1].val != req[t] || got_q[got_q.size()-1].ch != 2) begin
        failures++;
        $display("FAIL saturation[%0d]: got %0d, required %0d on ch 2", t,
                 (got_q.size() == 0) ? 0 : got_q[got_q.size()-1].val, req[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] hold;
    cfg(2, 0);
    got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) try_send(0, i + 1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
    end
    hold = out;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (out !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: out=%h out_valid=%b in_ready=%b, required %h/1/0",
                 out, out_valid, in_ready, hold);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (got_q.size() != 1 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_single: got %0d transfers out_valid=%b, required 1 transfer and 1", got_q.size(), out_valid);
    end
    out_ready = 1'b1;
    drain();
    checks++;
    if (got_q.size() != m_accepts / 2) begin
      failures++;
      $display("FAIL bp_total: got %0d outputs, required %0d", got_q.size(), m_accepts / 2);
    end
  endtask

  task automatic test_flush_and_midreset();
    cfg(2, 0);
    repeat (4) send(0, 5);
    cfg(3, 0);
    repeat (15) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush: out_valid=%b, required 0", out_valid);
      end
      @(posedge clk); #1;
    end
    cfg(2, 0);
    repeat (4) send(1, 7);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset: out_valid=%b in_ready=%b, required 0/0", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    model_reset(2, 0);
    repeat (15) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle: out_valid=%b, required 0", out_valid);
      end
      @(posedge clk); #1;
    end
    got_q.delete();
    repeat (12) send(3, 1);
    drain();
    checks++;
    if (got_q.size() != 6 || got_q[got_q.size()-1].val != 8) begin
      failures++;
      $display("FAIL reset_default_rate: got %0d outputs last=%0d, required 6 outputs last=8",
               got_q.size(), (got_q.size() == 0) ? 0 : got_q[got_q.size()-1].val);
    end
  endtask

  initial begin
    model_reset(2, 0);
    test_reset();
    test_dc_gain();
    test_channel_isolation();
    test_rate_round();
    test_saturation();
    test_backpressure();
    test_flush_and_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_decimator_mc.md
Name: cic_decimator_mc

Overview:
Multi-channel CIC decimator with a rate that is set at runtime.
- Accepts time-division-multiplexed samples tagged with a channel index.
- Keeps per-channel integrator and comb state.
- Rounds, shifts and saturates each decimated result, then emits it on a valid/ready stream with its channel tag.
- Sits between the channeliser/NCO mixer and downstream FIR compensation. Supersedes the single-channel fixed-rate decimator.

Parameters:
- InputLengthBits, 12: signed input sample width.
- NumChannels, 4: number of TDM channels; must be ≥1.
- FilterOrder, 3: number of integrator stages and of comb stages (N).
- DelayLength, 1: comb differential delay M; legal values are 1 or 2.
- MaxDecimation, 64: largest legal runtime rate R.
- InternalLengthBits, 30: accumulator width. Must be ≥ InputLengthBits + FilterOrder*ceil(log2(MaxDecimation*DelayLength)).
- OutputLengthBits, 16: signed output width.
- ChannelBits, $clog2(NumChannels) (min 1): width of channel tags.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- rate, in, $clog2(MaxDecimation+1): decimation factor R; legal range 2..MaxDecimation.
- shift, in, 6: arithmetic right shift applied before output.
- cfg_load, in, 1: pulse; latches rate/shift and flushes all state.
- in, in, InputLengthBits: signed sample.
- in_channel, in, ChannelBits: channel tag of in.
- in_valid, in, 1: in/in_channel valid.
- in_ready, out, 1: block accepts the sample this cycle.
- out, out, OutputLengthBits: signed decimated sample.
- out_channel, out, ChannelBits: channel tag of out.
- out_valid, out, 1: out/out_channel valid.
- out_ready, in, 1: consumer accepts.

Behaviour:
- Reset (rst low, async):
  - All integrator, comb and delay state and all per-channel phase counters clear to 0.
  - out, out_channel and out_valid clear to 0.
  - Latched rate becomes 2 and latched shift becomes 0.
  - in_ready is 0 while in reset.
  - Reset applied mid-stream discards all in-flight data; there is no partial output.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - in_ready = !(out_valid && !out_ready). The pipeline stalls as a whole while the output is held.
  - out/out_channel stay stable while out_valid && !out_ready.
  - out_valid drops on the cycle after a transfer unless a new result arrives that cycle.
- Integrator stage:
  - On accept, channel c's N integrators update in one cycle: I1 += in (sign-extended), Ik += I(k-1) (cascaded, pre-update values).
  - Arithmetic wraps modulo 2^InternalLengthBits; wrap is intentional and is cancelled by the combs.
- Decimation:
  - Per-channel phase counter increments on each accept for that channel.
  - When it reaches R-1 it wraps to 0, and IN is forwarded with tag c into the comb pipeline.
  - Other channels' counters are unaffected.
  - Samples with in_channel ≥ NumChannels are accepted and dropped.
- Comb pipeline:
  - N registered stages. Each stage computes Ck = x - x_delayed[c], using per-channel delay lines of depth M.
  - Delay lines update only when that stage processes a sample for channel c.
- Output stage (registered):
  - Compute y = (C_N + 2^(shift-1)) >>> shift (round half up; when shift = 0 no rounding term is added).
  - Saturate y to [-2^(OutputLengthBits-1), 2^(OutputLengthBits-1)-1].
- Latency: from accept of the decimating sample to out_valid is N+2 cycles (integrator reg, N comb regs, output reg), absent stalls.
- Throughput: one input per cycle.
- Gain: DC gain is (R*M)^N before the shift.
- cfg_load:
  - Flushes all state, drops in-flight results, and deasserts out_valid next cycle.
  - Latches rate (values <2 clamp to 2; values >MaxDecimation clamp to MaxDecimation) and shift.
  - in_ready is 0 during the cfg_load cycle.
- Simultaneous events: cfg_load takes priority over an accept in the same cycle; that sample is dropped.

Decomposition:
- Package cic_pkg holds:
  - sample typedefs parameterised by width;
  - a constant function cic_min_internal_bits(in_bits, order, rate, delay);
  - a saturate/round helper function.
- One natural sub-module: cic_comb_stage. It holds one registered comb stage with a per-channel delay RAM/regs, a stall input and a channel tag passthrough. It is instantiated FilterOrder times.

Test Plan:
- Reset/hold: rst low, in_valid=1, in=12'hAAA for 100 cycles -> out=0, out_valid=0, in_ready=0.
- DC gain: N=3, M=1, R=5, shift=0, ch0 in=1 continuous -> after settling every out=125, out_channel=0; first out_valid 5 (=N+2) cycles after the 5th accept.
- Channel isolation: interleaved ch0 in=1 and ch1 in=-2, R=5 -> alternating out=125 (ch0) and -250 (ch1), never cross-mixed.
- Runtime rate and round: cfg_load with rate=4, shift=2, ch0 in=3 -> out=48 (192>>2); then rate=5, shift=2, in=3 -> 375/4=93.75 -> out=94.
- Saturation: OutputLengthBits=16, shift=0, R=5, in=2047 -> out=32767; in=-2048 -> out=-32768.
- Backpressure: out_ready=0 while results pending -> out_valid holds, out stable, in_ready=0. Release out_ready for one cycle -> one transfer, no lost or duplicated outputs versus the golden sequence.
